seg_serial_driver: RTL



---
 rtl/seg_pkg.sv | 14 +
 rtl/seg_serial_driver_refresh_timer.sv | 28 ++
 rtl/seg_serial_driver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state type and sizing helpers for the segment serial driver
package seg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} seg_state_t;

  localparam int SEG_DATA_W = 64;
  localparam int SEG_IDX_W  = $clog2(SEG_DATA_W);

  // Counter width that stays legal (>=1 bit) for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_serial_driver_refresh_timer.sv
// rtl/seg_serial_driver_refresh_timer.sv - free-running wrap counter with a one-cycle tick
module refresh_timer
  import seg_pkg::*;
#(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW   = idx_width(CYCLES);
  localparam int LAST = (CYCLES > 0) ? CYCLES - 1 : 0;

  logic [CW-1:0] count;

  // With CYCLES == 0 the counter parks at zero and the tick is forced low.
  always_ff @(posedge clk) begin
    if (rst || count == CW'(LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (CYCLES != 0) && (count == CW'(LAST));

endmodule

// File: rtl/seg_serial_driver.sv
// rtl/seg_serial_driver.sv - snapshots the display word and shifts it into a 74HC595-style chain
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int DATA_W         = SEG_DATA_W,
  parameter int DIV            = 2,
  parameter int REFRESH_CYCLES = 50000,
  parameter bit INVERT         = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] show_data,
  input  logic              update,
  output logic              seg_clk,
  output logic              seg_sout,
  output logic              seg_latch,
  output logic              seg_clrn,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam int PH_W  = idx_width(2 * DIV);
  localparam logic [PH_W-1:0] PH_LOW_END = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(2 * DIV - 1);

  seg_state_t        state;
  logic              pending;
  logic [DATA_W-1:0] shadow;
  logic [IDX_W-1:0]  bit_idx;
  logic [PH_W-1:0]   phase;
  logic              tick;
  logic              capture;
  logic [DATA_W-1:0] snap;

  refresh_timer #(.CYCLES(REFRESH_CYCLES)) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign snap = INVERT ? ~show_data : show_data;

  // A pending request is served from IDLE or straight off the last latch cycle,
  // so back-to-back frames keep busy high with no gap.
  assign capture = pending && ((state == IDLE) ||
                               (state == LATCH && phase == PH_LOW_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      shadow    <= '0;
      bit_idx   <= '0;
      phase     <= '0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
      done     <= 1'b0;

      if (capture) begin
        pending <= 1'b0;
      end else if (update || tick) begin
        pending <= 1'b1;
      end

      if (capture) begin
        shadow    <= snap;
        bit_idx   <= IDX_W'(DATA_W - 1);
        phase     <= '0;
        seg_sout  <= snap[DATA_W-1];
        seg_clk   <= 1'b0;
        seg_latch <= 1'b0;
        busy      <= 1'b1;
        state     <= SHIFT;
        if (state == LATCH) done <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            seg_sout <= 1'b0;
          end
          SHIFT: begin
            if (phase == PH_LAST) begin
              phase   <= '0;
              seg_clk <= 1'b0;
              if (bit_idx == '0) begin
                state     <= LATCH;
                seg_latch <= 1'b1;
                seg_sout  <= 1'b0;
              end else begin
                bit_idx  <= bit_idx - 1'b1;
                seg_sout <= shadow[bit_idx - 1'b1];
              end
            end else begin
              phase <= phase + 1'b1;
              if (phase == PH_LOW_END) seg_clk <= 1'b1;
            end
          end
          LATCH: begin
            if (phase == PH_LOW_END) begin
              state     <= IDLE;
              seg_latch <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
